riscv_v_wb_stage: RTL and testbench
===================================

Name: riscv_v_wb_stage

Overview:
- Vector writeback stage: the producer end of the decode stage's write interface.
- Accepts completed execute results through a valid/ready handshake and buffers them in a small in-order queue.
- Retires them as single-cycle write strobes to the vector RF, the mask RF and the shared integer RF write port.
- Forwards pending, not-yet-written vector results back to the decode read path.

Parameters:
DATA_W, 128, vector register width in bits
ADDR_W, 5, vector/integer register address width
INT_W, 32, integer register data width
BE_W, DATA_W/8, byte-enable width (16); also mask data width
DEPTH, 2, result queue entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous pipe clear
exe_valid  in  1  execute result valid
exe_ready  out  1  queue can accept this cycle
exe_vd  in  ADDR_W  vector destination
exe_be  in  BE_W  per-byte vector write enables
exe_data  in  DATA_W  vector result
exe_mask_we  in  1  mask RF write request
exe_mask_data  in  BE_W  mask result
exe_int_we  in  1  integer RF write request (v2i)
exe_int_rd  in  ADDR_W  integer destination
exe_int_data  in  INT_W  integer result
rf_wr_en  out  BE_W  vector RF byte write strobes
rf_wr_addr  out  ADDR_W  vector RF write address
rf_wr_data  out  DATA_W  vector RF write data
mask_rf_wr_en  out  1  mask RF write strobe
mask_rf_wr_addr  out  ADDR_W  mask RF address (= entry vd)
mask_rf_wr_data  out  BE_W  mask write data
int_wr_req  out  1  request for shared integer write port
int_wr_gnt  in  1  integer write port granted this cycle
int_wr_addr  out  ADDR_W  integer write address
int_wr_data  out  INT_W  integer write data
fwd_addr  in  ADDR_W  decode read address to check
fwd_hit  out  1  pending vector write to fwd_addr
fwd_be  out  BE_W  byte enables of matching entry
fwd_data  out  DATA_W  data of matching entry
occupancy  out  $clog2(DEPTH)+1  entries held

Behaviour:
- Reset (async, rst=1): queue empty, occupancy=0, all strobes/req/fwd_hit=0, data/address outputs 0. Applies immediately mid-operation; a pending int_wr_req drops in the same cycle with no write.
- Accept: entry enqueued at the clk edge where exe_valid&&exe_ready&&!flush. All exe_* fields are captured together.
- exe_ready = (occupancy<DEPTH) || retire, where retire is the same-cycle retirement of the head; full-with-retire accepts.
- Head retire condition: occupancy>0 && !flush && (!head.int_we || int_wr_gnt).
- Retire cycle drives all outputs combinationally from the head entry for exactly one cycle:
  - rf_wr_en=head.be
  - mask_rf_wr_en=head.mask_we
  - address/data outputs from the head
  - The head is dequeued at the following edge.
- Non-retire cycles: rf_wr_en=0, mask_rf_wr_en=0.
- No partial write of a head ever occurs while it waits for int_wr_gnt.
- int_wr_req=occupancy>0 && head.int_we && !flush. While waiting, it is held with stable int_wr_addr/int_wr_data until granted.
- int_wr_gnt without int_wr_req is ignored.
- Latency: a result accepted at edge N writes in cycle N+1 when the head is free; sustained throughput is 1 per cycle with no int stalls.
- No-op entry (be=0, mask_we=0, int_we=0): occupies a slot and retires with all strobes 0.
- Ordering: strictly in order; the pointers wrap modulo DEPTH.
- Flush: in the flush cycle, no strobes, no request, no accept. All entries are discarded at the edge; occupancy=0 next cycle.
- Forwarding (combinational):
  - Scan valid entries youngest to oldest and select the first with vd==fwd_addr and be!=0.
  - fwd_hit=1, fwd_be/fwd_data from that entry; otherwise fwd_hit=0, fwd_be=0, fwd_data=0.
  - Includes the head even in its retire cycle.
  - Excludes the entry being accepted this cycle.
- Simultaneous accept+retire keeps occupancy unchanged; occupancy never exceeds DEPTH.

Test Plan:
- Reset then exe_valid with vd=3, be=16'hFFFF, data=128'hA5.. → cycle+1: rf_wr_en=16'hFFFF, rf_wr_addr=3, single cycle; occupancy 1→0.
- Back-to-back 4 results vd=1..4, no int writes → four consecutive write cycles, exe_ready stays 1, occupancy never >1.
- Entry with int_we=1, rd=7, data=32'hDEADBEEF, int_wr_gnt=0 for 5 cycles:
  - int_wr_req stays high with stable addr/data, no vector strobe.
  - Two more accepts fill the queue; exe_ready=0.
  - gnt=1 → head retires and exe_ready=1 in the same cycle.
- Queue holds vd=5 be=16'h00FF data X (older) and vd=5 be=16'hFF00 data Y (younger); fwd_addr=5 → fwd_hit=1, fwd_be=16'hFF00, fwd_data=Y. fwd_addr=6 → fwd_hit=0.
- Two entries pending with gnt=0, flush=1 for one cycle while exe_valid=1 → no strobes that cycle, occupancy=0 next cycle, the incoming result is discarded.
- rst asserted asynchronously mid-cycle with int_wr_req=1 → req and all strobes drop before the next edge, occupancy=0; after release, normal accept resumes.

Source files
------------

// File: rtl/riscv_v_wb_stage.sv
// Vector writeback stage: buffers execute results in an in-order queue and retires them
// as one-cycle write strobes to the vector, mask and shared integer register files.
module riscv_v_wb_stage #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 5,
    parameter int INT_W  = 32,
    parameter int BE_W   = DATA_W / 8,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,

    input  logic                       exe_valid,
    output logic                       exe_ready,
    input  logic [ADDR_W-1:0]          exe_vd,
    input  logic [BE_W-1:0]            exe_be,
    input  logic [DATA_W-1:0]          exe_data,
    input  logic                       exe_mask_we,
    input  logic [BE_W-1:0]            exe_mask_data,
    input  logic                       exe_int_we,
    input  logic [ADDR_W-1:0]          exe_int_rd,
    input  logic [INT_W-1:0]           exe_int_data,

    output logic [BE_W-1:0]            rf_wr_en,
    output logic [ADDR_W-1:0]          rf_wr_addr,
    output logic [DATA_W-1:0]          rf_wr_data,

    output logic                       mask_rf_wr_en,
    output logic [ADDR_W-1:0]          mask_rf_wr_addr,
    output logic [BE_W-1:0]            mask_rf_wr_data,

    output logic                       int_wr_req,
    input  logic                       int_wr_gnt,
    output logic [ADDR_W-1:0]          int_wr_addr,
    output logic [INT_W-1:0]           int_wr_data,

    input  logic [ADDR_W-1:0]          fwd_addr,
    output logic                       fwd_hit,
    output logic [BE_W-1:0]            fwd_be,
    output logic [DATA_W-1:0]          fwd_data,

    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] vd;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] data;
        logic              mask_we;
        logic [BE_W-1:0]   mask_data;
        logic              int_we;
        logic [ADDR_W-1:0] int_rd;
        logic [INT_W-1:0]  int_data;
    } entry_t;

    entry_t           queue [DEPTH];
    entry_t           head;
    entry_t           incoming;
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [OCC_W-1:0] occ;
    logic             not_empty;
    logic             retire;
    logic             accept;

    assign not_empty = (occ != '0);
    assign head      = queue[head_ptr];

    // A head waiting for the integer port stays put in full; nothing is written piecemeal.
    assign retire    = not_empty && !flush && (!head.int_we || int_wr_gnt);
    assign exe_ready = (occ < FULL_OCC) || retire;
    assign accept    = exe_valid && exe_ready && !flush;
    assign occupancy = occ;

    always_comb begin
        incoming           = '0;
        incoming.vd        = exe_vd;
        incoming.be        = exe_be;
        incoming.data      = exe_data;
        incoming.mask_we   = exe_mask_we;
        incoming.mask_data = exe_mask_data;
        incoming.int_we    = exe_int_we;
        incoming.int_rd    = exe_int_rd;
        incoming.int_data  = exe_int_data;
    end

    // NOTE: queue storage has no reset; occupancy alone defines which slots are valid,
    // and every output derived from storage is gated by it.
    always_ff @(posedge clk) begin
        if (accept) begin
            queue[tail_ptr] <= incoming;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update
    // from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            occ      <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            occ      <= '0;
        end else begin
            if (accept) begin
                tail_ptr <= tail_ptr + 1'b1;
            end
            if (retire) begin
                head_ptr <= head_ptr + 1'b1;
            end
            case ({accept, retire})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // NOTE: every output assigned here gets a default first so no latch is inferred.
    always_comb begin
        rf_wr_en        = '0;
        rf_wr_addr      = '0;
        rf_wr_data      = '0;
        mask_rf_wr_en   = 1'b0;
        mask_rf_wr_addr = '0;
        mask_rf_wr_data = '0;
        int_wr_req      = 1'b0;
        int_wr_addr     = '0;
        int_wr_data     = '0;
        if (not_empty) begin
            rf_wr_addr      = head.vd;
            rf_wr_data      = head.data;
            mask_rf_wr_addr = head.vd;
            mask_rf_wr_data = head.mask_data;
            int_wr_addr     = head.int_rd;
            int_wr_data     = head.int_data;
            int_wr_req      = head.int_we && !flush;
        end
        if (retire) begin
            rf_wr_en      = head.be;
            mask_rf_wr_en = head.mask_we;
        end
    end

    // Walk oldest to youngest so the last match, the youngest writer, wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_be   = '0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (OCC_W'(k) < occ) begin
                if (queue[head_ptr + PTR_W'(k)].vd == fwd_addr &&
                    queue[head_ptr + PTR_W'(k)].be != '0) begin
                    fwd_hit  = 1'b1;
                    fwd_be   = queue[head_ptr + PTR_W'(k)].be;
                    fwd_data = queue[head_ptr + PTR_W'(k)].data;
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_v_wb_stage.sv
// Directed bench for riscv_v_wb_stage: writeback timing, integer-port stalls,
// forwarding priority, flush and asynchronous reset.
module tb_riscv_v_wb_stage;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         exe_valid;
    logic         exe_ready;
    logic [4:0]   exe_vd;
    logic [15:0]  exe_be;
    logic [127:0] exe_data;
    logic         exe_mask_we;
    logic [15:0]  exe_mask_data;
    logic         exe_int_we;
    logic [4:0]   exe_int_rd;
    logic [31:0]  exe_int_data;
    logic [15:0]  rf_wr_en;
    logic [4:0]   rf_wr_addr;
    logic [127:0] rf_wr_data;
    logic         mask_rf_wr_en;
    logic [4:0]   mask_rf_wr_addr;
    logic [15:0]  mask_rf_wr_data;
    logic         int_wr_req;
    logic         int_wr_gnt;
    logic [4:0]   int_wr_addr;
    logic [31:0]  int_wr_data;
    logic [4:0]   fwd_addr;
    logic         fwd_hit;
    logic [15:0]  fwd_be;
    logic [127:0] fwd_data;
    logic [1:0]   occupancy;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] DATA_A5 = {16{8'hA5}};
    localparam logic [127:0] DATA_X  = {4{32'h1111_2222}};
    localparam logic [127:0] DATA_Y  = {4{32'h3333_4444}};
    localparam logic [127:0] DATA_Z  = {4{32'h5A5A_0F0F}};

    riscv_v_wb_stage dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .exe_valid       (exe_valid),
        .exe_ready       (exe_ready),
        .exe_vd          (exe_vd),
        .exe_be          (exe_be),
        .exe_data        (exe_data),
        .exe_mask_we     (exe_mask_we),
        .exe_mask_data   (exe_mask_data),
        .exe_int_we      (exe_int_we),
        .exe_int_rd      (exe_int_rd),
        .exe_int_data    (exe_int_data),
        .rf_wr_en        (rf_wr_en),
        .rf_wr_addr      (rf_wr_addr),
        .rf_wr_data      (rf_wr_data),
        .mask_rf_wr_en   (mask_rf_wr_en),
        .mask_rf_wr_addr (mask_rf_wr_addr),
        .mask_rf_wr_data (mask_rf_wr_data),
        .int_wr_req      (int_wr_req),
        .int_wr_gnt      (int_wr_gnt),
        .int_wr_addr     (int_wr_addr),
        .int_wr_data     (int_wr_data),
        .fwd_addr        (fwd_addr),
        .fwd_hit         (fwd_hit),
        .fwd_be          (fwd_be),
        .fwd_data        (fwd_data),
        .occupancy       (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] vd, input logic [15:0] be, input logic [127:0] data,
                         input logic mwe, input logic [15:0] mdata,
                         input logic iwe, input logic [4:0] ird, input logic [31:0] idata);
        exe_valid     = 1'b1;
        exe_vd        = vd;
        exe_be        = be;
        exe_data      = data;
        exe_mask_we   = mwe;
        exe_mask_data = mdata;
        exe_int_we    = iwe;
        exe_int_rd    = ird;
        exe_int_data  = idata;
    endtask

    task automatic idle();
        exe_valid     = 1'b0;
        exe_vd        = '0;
        exe_be        = '0;
        exe_data      = '0;
        exe_mask_we   = 1'b0;
        exe_mask_data = '0;
        exe_int_we    = 1'b0;
        exe_int_rd    = '0;
        exe_int_data  = '0;
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        int_wr_gnt = 1'b0;
        fwd_addr   = '0;
        idle();
        #2;
        check("rst_occ",   occupancy, 0);
        check("rst_wr_en", rf_wr_en, 0);
        check("rst_req",   int_wr_req, 0);
        check("rst_fwd",   fwd_hit, 0);
        check("rst_ready", exe_ready, 1);
        tick();
        tick();
        rst = 1'b0;

        // Single result: written in the cycle after acceptance, for one cycle only.
        drive(5'd3, 16'hFFFF, DATA_A5, 1'b0, 16'h0, 1'b0, 5'd0, 32'h0);
        fwd_addr = 5'd3;
        #2;
        check("t1_ready",       exe_ready, 1);
        check("t1_pre_wr_en",   rf_wr_en, 0);
        check("t1_fwd_excl",    fwd_hit, 0);
        tick();
        idle();
        #2;
        check("t1_wr_en",       rf_wr_en, 16'hFFFF);
        check("t1_wr_addr",     rf_wr_addr, 3);
        check("t1_wr_data",     rf_wr_data, DATA_A5);
        check("t1_occ1",        occupancy, 1);
        check("t1_fwd_head",    fwd_hit, 1);
        check("t1_fwd_data",    fwd_data, DATA_A5);
        tick();
        #2;
        check("t1_single",      rf_wr_en, 0);
        check("t1_occ0",        occupancy, 0);

        // Four back-to-back results retire on four consecutive cycles.
        for (int i = 1; i <= 4; i++) begin
            drive(5'(i), 16'h0F0F, 128'(i), 1'b0, 16'h0, 1'b0, 5'd0, 32'h0);
            #2;
            check("t2_ready", exe_ready, 1);
            if (i == 1) begin
                check("t2_first_idle", rf_wr_en, 0);
                check("t2_occ_first", occupancy, 0);
            end else begin
                check("t2_wr_en", rf_wr_en, 16'h0F0F);
                check("t2_wr_addr", rf_wr_addr, i - 1);
                check("t2_occ", occupancy, 1);
            end
            tick();
        end
        idle();
        #2;
        check("t2_last_addr", rf_wr_addr, 4);
        check("t2_last_en",   rf_wr_en, 16'h0F0F);
        tick();
        #2;
        check("t2_drain", occupancy, 0);

        // Grant without a request is ignored.
        int_wr_gnt = 1'b1;
        #2;
        check("gnt_noreq_en",  rf_wr_en, 0);
        check("gnt_noreq_occ", occupancy, 0);
        tick();
        int_wr_gnt = 1'b0;

        // Integer write stalls the head until granted; no partial vector/mask write.
        drive(5'd9, 16'hFFFF, DATA_X, 1'b1, 16'hBEEF, 1'b1, 5'd7, 32'hDEADBEEF);
        #2;
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            #2;
            check("t3_req",     int_wr_req, 1);
            check("t3_addr",    int_wr_addr, 7);
            check("t3_data",    int_wr_data, 32'hDEADBEEF);
            check("t3_no_vec",  rf_wr_en, 0);
            check("t3_no_mask", mask_rf_wr_en, 0);
            tick();
        end
        drive(5'd10, 16'h000F, DATA_Y, 1'b0, 16'h0, 1'b0, 5'd0, 32'h0);
        #2;
        check("t3_ready_1", exe_ready, 1);
        tick();
        drive(5'd11, 16'h00F0, DATA_Z, 1'b0, 16'h0, 1'b0, 5'd0, 32'h0);
        #2;
        check("t3_full_ready", exe_ready, 0);
        check("t3_full_occ",   occupancy, 2);
        check("t3_full_req",   int_wr_req, 1);
        check("t3_full_no_vec", rf_wr_en, 0);
        tick();
        int_wr_gnt = 1'b1;
        #2;
        check("t3_gnt_ready",  exe_ready, 1);
        check("t3_gnt_wr_en",  rf_wr_en, 16'hFFFF);
        check("t3_gnt_addr",   rf_wr_addr, 9);
        check("t3_gnt_mask",   mask_rf_wr_en, 1);
        check("t3_gnt_maddr",  mask_rf_wr_addr, 9);
        check("t3_gnt_mdata",  mask_rf_wr_data, 16'hBEEF);
        tick();
        int_wr_gnt = 1'b0;
        idle();
        #2;
        check("t3_occ_kept",   occupancy, 2);
        check("t3_next_en",    rf_wr_en, 16'h000F);
        check("t3_next_addr",  rf_wr_addr, 10);
        tick();
        #2;
        check("t3_last_en",    rf_wr_en, 16'h00F0);
        check("t3_last_addr",  rf_wr_addr, 11);
        check("t3_last_occ",   occupancy, 1);
        tick();
        #2;
        check("t3_drain",      occupancy, 0);

        // No-op entry occupies a slot and retires silently; never forwards.
        drive(5'd2, 16'h0, DATA_Y, 1'b0, 16'h0, 1'b0, 5'd0, 32'h0);
        #2;
        tick();
        idle();
        fwd_addr = 5'd2;
        #2;
        check("noop_occ",   occupancy, 1);
        check("noop_en",    rf_wr_en, 0);
        check("noop_mask",  mask_rf_wr_en, 0);
        check("noop_req",   int_wr_req, 0);
        check("noop_fwd",   fwd_hit, 0);
        tick();
        #2;
        check("noop_drain", occupancy, 0);

        // Forwarding picks the youngest matching entry.
        drive(5'd5, 16'h00FF, DATA_X, 1'b0, 16'h0, 1'b1, 5'd1, 32'h1);
        #2;
        tick();
        drive(5'd5, 16'hFF00, DATA_Y, 1'b0, 16'h0, 1'b0, 5'd0, 32'h0);
        #2;
        tick();
        idle();
        fwd_addr = 5'd5;
        #2;
        check("t4_occ",      occupancy, 2);
        check("t4_hit",      fwd_hit, 1);
        check("t4_be",       fwd_be, 16'hFF00);
        check("t4_data",     fwd_data, DATA_Y);
        fwd_addr = 5'd6;
        #2;
        check("t4_miss",     fwd_hit, 0);
        check("t4_miss_be",  fwd_be, 0);
        check("t4_miss_dat", fwd_data, 0);
        tick();

        // Flush with two pending entries and an incoming result.
        flush = 1'b1;
        drive(5'd12, 16'hFFFF, DATA_Z, 1'b1, 16'h1, 1'b0, 5'd0, 32'h0);
        #2;
        check("t5_no_en",   rf_wr_en, 0);
        check("t5_no_mask", mask_rf_wr_en, 0);
        check("t5_no_req",  int_wr_req, 0);
        tick();
        flush = 1'b0;
        idle();
        fwd_addr = 5'd12;
        #2;
        check("t5_occ",     occupancy, 0);
        check("t5_fwd12",   fwd_hit, 0);
        check("t5_en_after", rf_wr_en, 0);
        fwd_addr = 5'd5;
        #2;
        check("t5_fwd5",    fwd_hit, 0);
        tick();

        // Asynchronous reset mid-cycle while an integer request is pending.
        drive(5'd0, 16'h0, 128'h0, 1'b0, 16'h0, 1'b1, 5'd20, 32'h1234_5678);
        #2;
        tick();
        idle();
        #2;
        check("t6_req_before", int_wr_req, 1);
        check("t6_addr_before", int_wr_addr, 20);
        rst = 1'b1;
        #1;
        check("t6_req_drop",  int_wr_req, 0);
        check("t6_occ",       occupancy, 0);
        check("t6_en",        rf_wr_en, 0);
        check("t6_int_addr",  int_wr_addr, 0);
        check("t6_int_data",  int_wr_data, 0);
        tick();
        rst = 1'b0;
        drive(5'd8, 16'h0F0F, DATA_Z, 1'b0, 16'h0, 1'b0, 5'd0, 32'h0);
        #2;
        check("t6_ready",     exe_ready, 1);
        tick();
        idle();
        #2;
        check("t6_wr_en",     rf_wr_en, 16'h0F0F);
        check("t6_wr_addr",   rf_wr_addr, 8);
        check("t6_wr_data",   rf_wr_data, DATA_Z);
        tick();
        #2;
        check("t6_drain",     occupancy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
